// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: issue-side controller for multi-cycle data-memory accesses.
// It latches a load/store from the MEM stage and stalls the pipeline while the
// access runs. It drives the wait-state counter's go input and watches its
// change output. A one-cycle ack, with err set on timeout, ends each access.
// Optional feature: define STALL_STATS_EN to add the 16-bit stall_cnt output,
// a saturating count of the cycles in which stall was asserted.
module mem_stall_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              change,
    output logic              go,
    output logic              stall,
    output logic              ack,
    output logic              err,
    output logic              lat_we,
    output logic [ADDR_W-1:0] lat_addr,
`ifdef STALL_STATS_EN
    output logic [DATA_W-1:0] lat_wdata,
    output logic [15:0]       stall_cnt
`else
    output logic [DATA_W-1:0] lat_wdata
`endif
);

    localparam int TC_W = $clog2(TIMEOUT) + 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [TC_W-1:0] tcnt;
    logic            err_q;

    // Access sequencing: accept and latch in IDLE, wait for change or timeout, then ack once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            err_q     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        lat_we    <= mem_we;
                        lat_addr  <= mem_addr;
                        lat_wdata <= mem_wdata;
                        tcnt      <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // change has priority, so a completion on the final allowed cycle is not an error
                    if (change) begin
                        err_q <= 1'b0;
                        state <= S_DONE;
                    end else if (tcnt == TC_LAST) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // go comes straight from the state register. Dropping it in DONE lets the wait-state counter reload.
    assign go    = (state == S_WAIT);
    assign ack   = (state == S_DONE);
    assign err   = err_q;
    // stall is low in DONE, so the pipeline advances at the end of the ack cycle
    assign stall = ((state == S_IDLE) && mem_req) || (state == S_WAIT);

`ifdef STALL_STATS_EN
    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
module tb_mem_stall_ctrl;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              change;
    logic              go, stall, ack, err, lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
`ifdef STALL_STATS_EN
    logic [15:0]       stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int mode   = 0;  // 0 counter model, 1 tied 0, 2 tied 1, 3 change on last timeout cycle

    mem_stall_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .change(change),
        .go(go), .stall(stall), .ack(ack), .err(err), .lat_we(lat_we),
        .lat_addr(lat_addr),
`ifdef STALL_STATS_EN
        .lat_wdata(lat_wdata), .stall_cnt(stall_cnt)
`else
        .lat_wdata(lat_wdata)
`endif
    );

    always #5 clk = ~clk;

    // Wait-state counter with reload value 1, plus other change sources
    logic [1:0] wcnt;
    int         gocnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt  <= 2'd1;
            gocnt <= 0;
        end else if (!go) begin
            wcnt  <= 2'd1;
            gocnt <= 0;
        end else begin
            if (wcnt != 2'd0) wcnt <= wcnt - 2'd1;
            gocnt <= gocnt + 1;
        end
    end

    always_comb begin
        change = 1'b0;
        case (mode)
            0: change = go && (wcnt == 2'd0);
            1: change = 1'b0;
            2: change = 1'b1;
            3: change = go && (gocnt == TIMEOUT - 1);
            default: change = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: m_k is the cycle index since the request was seen (-1 idle).
    // m_done_at is the index of the ack cycle once it is known (0 while still waiting).
    int          m_k, m_done_at, m_scnt;
    logic        m_err, m_we;
    logic [31:0] m_addr, m_wdata;

    function automatic bit m_waiting();
        return (m_k >= 1) && (m_done_at == 0);
    endfunction
    function automatic bit m_acking();
        return (m_k >= 1) && (m_done_at != 0) && (m_k == m_done_at);
    endfunction
    function automatic bit m_stall();
        return ((m_k < 0) && mem_req) || m_waiting();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = -1; m_done_at = 0; m_err = 0; m_we = 0;
            m_addr = 0; m_wdata = 0; m_scnt = 0;
        end else begin
            if (m_stall() && m_scnt < 65535) m_scnt++;
            if (m_k < 0) begin
                if (mem_req) begin
                    m_k = 1; m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
                end
            end else if (m_done_at == 0) begin
                if (change) begin
                    m_done_at = m_k + 1; m_err = 0;
                end else if (m_k == TIMEOUT) begin
                    m_done_at = m_k + 1; m_err = 1;
                end
                m_k++;
            end else begin
                m_k = -1; m_done_at = 0; m_err = 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_go", 32'(go), 32'(m_waiting()));
            chk("m_ack", 32'(ack), 32'(m_acking()));
            chk("m_err", 32'(err), 32'(m_acking() && m_err));
            chk("m_stall", 32'(stall), 32'(m_stall()));
            chk("m_lat_we", 32'(lat_we), 32'(m_we));
            chk("m_lat_addr", lat_addr, m_addr);
            chk("m_lat_wdata", lat_wdata, m_wdata);
`ifdef STALL_STATS_EN
            chk("m_stall_cnt", 32'(stall_cnt), 32'(m_scnt));
`endif
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mode = 0;
        @(negedge clk);
        chk("rst_go", 32'(go), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_lat_addr", lat_addr, 0);
        chk("rst_lat_we", 32'(lat_we), 0);
        next_cyc();
        rst = 1'b0;

        // T1 load
        next_cyc();
        mem_req = 1; mem_we = 0; mem_addr = 32'h10; mem_wdata = 32'hAAAA;
        @(negedge clk); chk("t1_c0_stall", 32'(stall), 1); chk("t1_c0_go", 32'(go), 0);
        next_cyc();
        @(negedge clk); chk("t1_c1_go", 32'(go), 1); chk("t1_c1_addr", lat_addr, 32'h10);
        next_cyc();
        @(negedge clk); chk("t1_c2_go", 32'(go), 1); chk("t1_c2_ack", 32'(ack), 0);
        next_cyc();
        @(negedge clk); chk("t1_c3_ack", 32'(ack), 1); chk("t1_c3_err", 32'(err), 0);
        chk("t1_c3_stall", 32'(stall), 0); chk("t1_c3_go", 32'(go), 0);
        next_cyc();
        mem_req = 0;
        @(negedge clk); chk("t1_c4_stall", 32'(stall), 0);

        // T2 store, then a second store held on after the ack
        next_cyc();
        mem_req = 1; mem_we = 1; mem_addr = 32'h30; mem_wdata = 32'h1234;
        @(negedge clk);
        next_cyc();
        mem_addr = 32'h99; mem_wdata = 32'h0;
        @(negedge clk); chk("t2_c1_addr", lat_addr, 32'h30); chk("t2_c1_we", 32'(lat_we), 1);
        chk("t2_c1_wdata", lat_wdata, 32'h1234);
        next_cyc();
        next_cyc();
        @(negedge clk); chk("t2_c3_ack", 32'(ack), 1); chk("t2_c3_addr", lat_addr, 32'h30);
        next_cyc();
        mem_addr = 32'h20; mem_wdata = 32'h5678;
        @(negedge clk); chk("t2_c4_stall", 32'(stall), 1); chk("t2_c4_ack", 32'(ack), 0);
        next_cyc();
        @(negedge clk); chk("t2_c5_addr", lat_addr, 32'h20); chk("t2_c5_we", 32'(lat_we), 1);
        chk("t2_c5_go", 32'(go), 1);
        next_cyc();
        next_cyc();
        @(negedge clk); chk("t2_c7_ack", 32'(ack), 1);
`ifdef STALL_STATS_EN
        chk("t6_stall_cnt", 32'(stall_cnt), 9);
`endif
        next_cyc();
        mem_req = 0;

        // T3 timeout with change tied low
        mode = 1;
        next_cyc();
        mem_req = 1; mem_we = 0; mem_addr = 32'h40;
        @(negedge clk);
        for (int k = 1; k <= 15; k++) begin
            next_cyc();
            @(negedge clk);
        end
        chk("t3_c15_go", 32'(go), 1); chk("t3_c15_ack", 32'(ack), 0);
        next_cyc();
        @(negedge clk); chk("t3_c16_ack", 32'(ack), 1); chk("t3_c16_err", 32'(err), 1);
        chk("t3_c16_go", 32'(go), 0);
        next_cyc();
        mem_req = 0;

        // change on the last allowed cycle wins over timeout
        mode = 3;
        next_cyc();
        mem_req = 1; mem_addr = 32'h44;
        for (int k = 0; k <= 15; k++) begin
            @(negedge clk);
            next_cyc();
        end
        @(negedge clk); chk("tc_c16_ack", 32'(ack), 1); chk("tc_c16_err", 32'(err), 0);
        next_cyc();
        mem_req = 0;

        // T4 reset mid-WAIT
        mode = 0;
        next_cyc();
        mem_req = 1; mem_addr = 32'h50;
        @(negedge clk);
        next_cyc();
        @(negedge clk); chk("t4_c1_go", 32'(go), 1);
        #2;
        rst = 1'b1; mem_req = 0;
        #1;
        chk("t4_rst_go", 32'(go), 0); chk("t4_rst_stall", 32'(stall), 0);
        chk("t4_rst_addr", lat_addr, 0); chk("t4_rst_ack", 32'(ack), 0);
        next_cyc();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("t4_idle_ack", 32'(ack), 0); chk("t4_idle_go", 32'(go), 0);
            next_cyc();
        end

        // T5 change high while idle
        mode = 2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("t5_go", 32'(go), 0); chk("t5_ack", 32'(ack), 0);
            chk("t5_stall", 32'(stall), 0);
            next_cyc();
        end
        mem_req = 1; mem_addr = 32'h60;
        @(negedge clk);
        next_cyc();
        next_cyc();
        @(negedge clk); chk("t5_c2_ack", 32'(ack), 1); chk("t5_c2_err", 32'(err), 0);
        next_cyc();
        mem_req = 0; mode = 0;
        next_cyc();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
